// File: rtl/faculty_fighter_pkg.sv
// faculty_fighter_pkg: shared coordinate, direction and projectile-slot types.
package faculty_fighter_pkg;
    typedef logic [9:0] coord_t;
    typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
        dir_e   dir;
    } proj_slot_t;
endpackage

// File: rtl/proj_slot.sv
// proj_slot: one projectile slot (state, per-tick move, bound check, hit check, pixel test).
// Ports: i_clk/i_rst clock and async reset; i_clr sync clear; i_tick frame tick;
//        i_spawn/i_x/i_y/i_dir load a new projectile; i_tgt_* target box;
//        i_draw_x/i_draw_y current pixel; o_active slot busy; o_hit hit on this tick;
//        o_pix current pixel lies on this projectile.
module proj_slot
    import faculty_fighter_pkg::*;
#(
    parameter int STEP      = 4,
    parameter int PROJ_SIZE = 4,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_clr,
    input  logic   i_tick,
    input  logic   i_spawn,
    input  coord_t i_x,
    input  coord_t i_y,
    input  logic   i_dir,
    input  coord_t i_tgt_x,
    input  coord_t i_tgt_y,
    input  coord_t i_tgt_w,
    input  coord_t i_tgt_h,
    input  coord_t i_draw_x,
    input  coord_t i_draw_y,
    output logic   o_active,
    output logic   o_hit,
    output logic   o_pix
);
    localparam logic signed [10:0] L_STEP = 11'(STEP);
    localparam logic signed [10:0] L_LO   = 11'(X_MIN + PROJ_SIZE);
    localparam logic signed [10:0] L_HI   = 11'(X_MAX - PROJ_SIZE);
    localparam logic signed [10:0] L_PS   = 11'(PROJ_SIZE);
    proj_slot_t r_s;
    logic signed [10:0] w_x, w_nx, w_dx, w_dy;
    logic signed [11:0] w_cx, w_cy, w_tx0, w_tx1, w_ty0, w_ty1;
    logic w_oob, w_in;
    // Target end coordinates can exceed 1023, so the hit compare is one bit wider than the move.
    always_comb begin
        w_x   = signed'({1'b0, r_s.x});
        w_nx  = (r_s.dir == DIR_LEFT) ? w_x - L_STEP : w_x + L_STEP;
        w_oob = (w_nx < L_LO) || (w_nx > L_HI);
        w_cx  = {w_nx[10], w_nx};
        w_cy  = signed'({2'b0, r_s.y});
        w_tx0 = signed'({2'b0, i_tgt_x});
        w_tx1 = w_tx0 + signed'({2'b0, i_tgt_w});
        w_ty0 = signed'({2'b0, i_tgt_y});
        w_ty1 = w_ty0 + signed'({2'b0, i_tgt_h});
        w_in  = (w_cx >= w_tx0) && (w_cx < w_tx1) && (w_cy >= w_ty0) && (w_cy < w_ty1);
        w_dx  = signed'({1'b0, i_draw_x}) - w_x;
        w_dy  = signed'({1'b0, i_draw_y}) - signed'({1'b0, r_s.y});
    end
    assign o_active = r_s.active;
    // Out-of-bounds wins over a hit: only in-bounds slots report.
    assign o_hit = i_tick && r_s.active && !w_oob && w_in;
    assign o_pix = r_s.active && (w_dx >= -L_PS) && (w_dx <= L_PS) && (w_dy >= -L_PS) && (w_dy <= L_PS);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s <= '0;
        end else if (i_clr) begin
            r_s <= '0;
        end else if (i_tick && r_s.active) begin
            r_s.x <= w_nx[9:0];
            if (w_oob || w_in) r_s.active <= 1'b0;
        end else if (i_spawn) begin
            r_s <= '{active: 1'b1, x: i_x, y: i_y, dir: dir_e'(i_dir)};
        end
    end
endmodule

// File: rtl/projectile_pool.sv
// projectile_pool: multi-slot projectile manager with cooldown, motion, despawn and hit detection.
// Ports: i_clk/i_rst clock and async reset; i_frame_clk VGA_VS (rising edge = frame tick);
//        i_enable battle active; i_fire shoot request; i_dir 0=right 1=left;
//        i_shooter_x/y spawn centre; i_target_* target box; i_draw_x/y current pixel;
//        o_is_proj pixel on a projectile; o_hit 1-clk hit pulse; o_hit_count hits on last tick;
//        o_active_mask per-slot active; o_cooldown_busy cooldown non-zero.
// Build option: PROJ_AUTOFIRE_EN makes a held fire request a shot on every tick.
module projectile_pool
    import faculty_fighter_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int STEP            = 4,
    parameter int PROJ_SIZE       = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_frame_clk,
    input  logic                               i_enable,
    input  logic                               i_fire,
    input  logic                               i_dir,
    input  logic [9:0]                         i_shooter_x,
    input  logic [9:0]                         i_shooter_y,
    input  logic [9:0]                         i_target_x,
    input  logic [9:0]                         i_target_y,
    input  logic [9:0]                         i_target_x_size,
    input  logic [9:0]                         i_target_y_size,
    input  logic [9:0]                         i_draw_x,
    input  logic [9:0]                         i_draw_y,
    output logic                               o_is_proj,
    output logic                               o_hit,
    output logic [$clog2(NUM_SLOTS+1)-1:0]     o_hit_count,
    output logic [NUM_SLOTS-1:0]               o_active_mask,
    output logic                               o_cooldown_busy
);
    localparam int CW  = $clog2(NUM_SLOTS + 1);
    localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    logic [1:0]           r_sync;
    logic                 r_vs_d, r_fire_d, r_pending, r_hit;
    logic [CDW-1:0]       r_cd;
    logic [CW-1:0]        r_hit_count, w_cnt;
    logic [NUM_SLOTS-1:0] w_free, w_first, w_spawn, w_hits, w_pix;
    logic                 w_tick, w_fire_rise, w_req, w_do_spawn;
    assign w_tick      = r_sync[1] && !r_vs_d && i_enable;
    assign w_fire_rise = i_fire && !r_fire_d;
`ifdef PROJ_AUTOFIRE_EN
    assign w_req = r_pending || w_fire_rise || i_fire;
`else
    assign w_req = r_pending || w_fire_rise;
`endif
    // Lowest-index free slot, judged on pre-tick state so a slot freed this tick waits one tick.
    assign w_free     = ~o_active_mask;
    assign w_first    = w_free & (~w_free + 1'b1);
    assign w_do_spawn = w_tick && w_req && (r_cd == '0) && (w_free != '0);
    assign w_spawn    = w_do_spawn ? w_first : '0;
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NUM_SLOTS; k++) w_cnt = w_cnt + CW'(w_hits[k]);
    end
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        proj_slot #(.STEP(STEP), .PROJ_SIZE(PROJ_SIZE), .X_MIN(X_MIN), .X_MAX(X_MAX)) u_slot (
            .i_clk(i_clk), .i_rst(i_rst), .i_clr(!i_enable), .i_tick(w_tick), .i_spawn(w_spawn[i]),
            .i_x(i_shooter_x), .i_y(i_shooter_y), .i_dir(i_dir),
            .i_tgt_x(i_target_x), .i_tgt_y(i_target_y), .i_tgt_w(i_target_x_size), .i_tgt_h(i_target_y_size),
            .i_draw_x(i_draw_x), .i_draw_y(i_draw_y),
            .o_active(o_active_mask[i]), .o_hit(w_hits[i]), .o_pix(w_pix[i])
        );
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync      <= '0;
            r_vs_d      <= 1'b0;
            r_fire_d    <= 1'b0;
            r_pending   <= 1'b0;
            r_cd        <= '0;
            r_hit       <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_sync   <= {r_sync[0], i_frame_clk};
            r_vs_d   <= r_sync[1];
            r_fire_d <= i_fire;
            r_hit    <= w_tick && (w_hits != '0);
            if (w_tick) r_hit_count <= w_cnt;
            if (!i_enable) begin
                r_pending <= 1'b0;
                r_cd      <= '0;
            end else if (w_tick) begin
                r_pending <= 1'b0;
                r_cd      <= w_do_spawn ? CDW'(COOLDOWN_FRAMES) : (r_cd != '0) ? r_cd - CDW'(1) : r_cd;
            end else if (w_fire_rise) begin
                r_pending <= 1'b1;
            end
        end
    end
    assign o_is_proj       = |w_pix;
    assign o_hit           = r_hit;
    assign o_hit_count     = r_hit_count;
    assign o_cooldown_busy = (r_cd != '0);
endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: directed scoreboard bench for projectile_pool.
module tb_projectile_pool;
    logic       clk = 1'b0, rst = 1'b1, frame_clk = 1'b0, enable = 1'b1, fire = 1'b0, dir = 1'b0;
    logic [9:0] shx = '0, shy = '0, tx = '0, ty = '0, tw = '0, th = '0, dx = '0, dy = '0;
    logic       is_proj, hit, busy;
    logic [2:0] hit_count;
    logic [3:0] mask;
    int         vectors = 0, errors = 0;
    int         hit_q[$];

    projectile_pool dut (
        .i_clk(clk), .i_rst(rst), .i_frame_clk(frame_clk), .i_enable(enable), .i_fire(fire), .i_dir(dir),
        .i_shooter_x(shx), .i_shooter_y(shy), .i_target_x(tx), .i_target_y(ty),
        .i_target_x_size(tw), .i_target_y_size(th), .i_draw_x(dx), .i_draw_y(dy),
        .o_is_proj(is_proj), .o_hit(hit), .o_hit_count(hit_count), .o_active_mask(mask),
        .o_cooldown_busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every hit pulse must match the next queued expected hit count.
    always @(negedge clk) begin
        if (!rst && hit) begin
            vectors++;
            if (hit_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hit: hit_count=%0d, no hit expected", hit_count);
            end else begin
                int e;
                e = hit_q.pop_front();
                if (32'(hit_count) != e) begin
                    errors++;
                    $display("FAIL hit_count_on_pulse: got %0d expected %0d", hit_count, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        repeat (6) @(posedge clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fire_edge();
        fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string name, input int x, input int y, input int exp);
        dx = 10'(x);
        dy = 10'(y);
        #1 chk(name, 32'(is_proj), exp);
    endtask

    task automatic clear_enable();
        enable = 1'b0;
        @(posedge clk);
        #1 chk("enable_clear_mask", 32'(mask), 0);
        chk("enable_clear_busy", 32'(busy), 0);
        enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mask", 32'(mask), 0);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_hit_count", 32'(hit_count), 0);
        chk("reset_busy", 32'(busy), 0);
        pix("reset_is_proj", 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single shot to hit: 281 + 4*20 = 361 enters [360,402).
        shx = 281; shy = 387; tx = 360; ty = 355; tw = 42; th = 64; dir = 1'b0;
        fire_edge();
        tick();
        chk("shot_spawn_mask", 32'(mask), 1);
        chk("shot_busy", 32'(busy), 1);
        pix("shot_pix_centre", 281, 387, 1);
        pix("shot_pix_corner", 285, 391, 1);
        pix("shot_pix_right_out", 286, 387, 0);
        pix("shot_pix_below_out", 281, 392, 0);
        ticks(19);
        chk("shot_before_hit_mask", 32'(mask), 1);
        hit_q.push_back(1);
        tick();
        chk("shot_after_hit_mask", 32'(mask), 0);
        chk("shot_hit_count", 32'(hit_count), 1);
        repeat (3) @(posedge clk);
        #1 chk("shot_hit_count_held", 32'(hit_count), 1);
        chk("shot_cooldown_done", 32'(busy), 0);

        // Cooldown drop; target moved off the flight path.
        ty = 0; th = 10; shy = 200;
        fire_edge();
        tick();
        chk("cd_first_spawn", 32'(mask), 1);
        chk("cd_hit_count_cleared", 32'(hit_count), 0);
        ticks(4);
        fire_edge();
        tick();
        chk("cd_second_dropped", 32'(mask), 1);
        ticks(10);
        chk("cd_expired_t15", 32'(busy), 0);
        tick();
        chk("cd_no_queued_shot_t16", 32'(mask), 1);
        fire_edge();
        tick();
        chk("cd_spawn_slot1", 32'(mask), 3);
        pix("cd_slot1_pos", 281, 200, 1);
        pix("cd_slot0_pos", 349, 200, 1);
        clear_enable();

        // Right edge: 630 -> 634 -> 638 despawns.
        shx = 630; dir = 1'b0;
        fire_edge();
        tick();
        chk("right_spawn", 32'(mask), 1);
        tick();
        chk("right_634_alive", 32'(mask), 1);
        pix("right_634_pix", 634, 200, 1);
        tick();
        chk("right_despawn", 32'(mask), 0);
        chk("right_no_hit", 32'(hit_count), 0);
        clear_enable();

        // Left edge: 6 -> 2 despawns on the first tick.
        shx = 6; dir = 1'b1;
        fire_edge();
        tick();
        chk("left_spawn", 32'(mask), 1);
        tick();
        chk("left_despawn", 32'(mask), 0);
        clear_enable();

        // Simultaneous hits: both slots reach X=200 together.
        tx = 200; ty = 190; tw = 20; th = 20; shy = 200; shx = 100; dir = 1'b0;
        fire_edge();
        tick();
        ticks(15);
        chk("sim_slot0_only", 32'(mask), 1);
        shx = 164;
        fire_edge();
        tick();
        chk("sim_two_slots", 32'(mask), 3);
        ticks(8);
        chk("sim_before_hit", 32'(mask), 3);
        hit_q.push_back(2);
        tick();
        chk("sim_after_hit_mask", 32'(mask), 0);
        chk("sim_hit_count", 32'(hit_count), 2);
        clear_enable();

        // Pool full: slot 0 at 300 despawns on tick 84 (636 > 635).
        ty = 400; shx = 300; dir = 1'b0;
        fire_edge();
        tick();
        shx = 10;
        for (int s = 1; s < 4; s++) begin
            ticks(15);
            fire_edge();
            tick();
        end
        chk("full_mask", 32'(mask), 15);
        ticks(15);
        fire_edge();
        tick();
        chk("full_fifth_dropped", 32'(mask), 15);
        pix("full_fifth_no_proj", 10, 200, 0);
        ticks(19);
        chk("full_t83_mask", 32'(mask), 15);
        fire_edge();
        tick();
        chk("full_t84_freed_not_reused", 32'(mask), 14);
        fire_edge();
        tick();
        chk("full_t85_reuse_slot0", 32'(mask), 15);
        pix("full_slot0_new_pos", 10, 200, 1);
        chk("full_busy", 32'(busy), 1);

        // Asynchronous reset mid-flight.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_mask", 32'(mask), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_hit_count", 32'(hit_count), 0);
        chk("async_rst_is_proj", 32'(is_proj), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Held fire: one shot normally, one per COOLDOWN_FRAMES+1 ticks with autofire.
        shx = 10; dir = 1'b0;
        fire = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        chk("hold_first_spawn", 32'(mask), 1);
        ticks(16);
`ifdef PROJ_AUTOFIRE_EN
        chk("hold_t16", 32'(mask), 3);
`else
        chk("hold_t16", 32'(mask), 1);
`endif
        fire = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("hit_queue_drained", hit_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/projectile_pool.md
Name: projectile_pool

Overview:
- Multi-slot projectile manager. One instance per shooter (player or NPC).
- Holds up to NUM_SLOTS bullets in flight at once. Handles fire cooldown, per-frame motion, screen-edge despawn and target hit detection.
- Drives the pixel hit-test flag read by the color mapper.
- Sits between the character block (shooter centre, target box) and the health/damage logic (hit pulse and hit count).

Parameters:
- NUM_SLOTS, 4, maximum concurrent projectiles (1..8).
- STEP, 4, pixels moved per frame, unsigned magnitude.
- PROJ_SIZE, 4, half-width of the square projectile in pixels.
- COOLDOWN_FRAMES, 15, frame ticks the shooter must wait after a spawn.
- X_MIN, 0, left screen limit.
- X_MAX, 639, right screen limit.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- frame_clk  in  1  VGA_VS; its rising edge defines the frame tick.
- enable  in  1  battle stage active; low clears all slots synchronously.
- fire  in  1  shoot request, level, already synchronised.
- dir  in  1  0 = right (+X), 1 = left (-X); sampled at spawn.
- Shooter_X_Center  in  10  spawn X position.
- Shooter_Y_Center  in  10  spawn Y position.
- Target_X  in  10  target box left edge.
- Target_Y  in  10  target box top edge.
- Target_X_Size  in  10  target box width.
- Target_Y_Size  in  10  target box height.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- is_proj  out  1  current pixel lies on any active projectile.
- hit  out  1  one-Clk pulse when one or more projectiles hit the target.
- hit_count  out  $clog2(NUM_SLOTS+1)  number of projectiles that hit on the last tick.
- active_mask  out  NUM_SLOTS  per-slot active flag.
- cooldown_busy  out  1  cooldown counter is non-zero.

Behaviour:
- Reset values: all slots inactive, positions 0, cooldown 0, pending 0. Outputs: hit=0, hit_count=0, active_mask=0, cooldown_busy=0. is_proj=0 follows from the inactive slots.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then a rising-edge detector.
  - frame_tick is a one-Clk pulse, 3 Clk after the VGA_VS rise.
- Fire capture:
  - A rising edge of fire sets the pending flag.
  - pending clears on every frame_tick, whether or not a spawn happened. A shot blocked by cooldown or a full pool is dropped, not queued.
- Order of operations on each frame_tick, using pre-tick state:
  1. Every active slot moves X ± STEP. Arithmetic is 11-bit signed to avoid wrap.
  2. Bound check: if the new X < X_MIN+PROJ_SIZE or > X_MAX−PROJ_SIZE, the slot deactivates.
  3. Hit check on surviving slots: centre inside [Target_X, Target_X+Target_X_Size) × [Target_Y, Target_Y+Target_Y_Size). On a hit the slot deactivates and is counted.
  4. Spawn: if pending, enable=1, cooldown==0 and a pre-tick free slot exists, the lowest-index free slot loads the shooter centre and dir. Cooldown then loads COOLDOWN_FRAMES.
  5. Otherwise, if cooldown is non-zero, it decrements.
- Slot reuse: a slot freed on tick N is spawnable on tick N+1, never on tick N.
- Newly spawned slot: not moved and not hit-tested on its spawn tick.
- Spawn rate: spawns are at least COOLDOWN_FRAMES+1 ticks apart.
- Hit outputs:
  - hit and hit_count are registered and valid the Clk after frame_tick.
  - hit is high for exactly 1 Clk.
  - hit_count holds its value until the next tick.
- Priority: a slot that goes out of bounds on a tick is not also counted as a hit.
- is_proj: combinational OR over active slots of |DrawX−X| ≤ PROJ_SIZE and |DrawY−Y| ≤ PROJ_SIZE, computed as signed 11-bit differences.
- enable low: synchronous clear of all slots, pending and cooldown, on the next Clk. Frame ticks are ignored while enable is low.
- Reset asserted mid-flight: immediate asynchronous clear, with no hit pulse.

Optional Feature:
- Macro: PROJ_AUTOFIRE_EN.
- Defined: pending is also set on any frame_tick where fire is held high. Holding fire spawns one projectile every COOLDOWN_FRAMES+1 ticks, subject to free slots.
- Undefined: only rising edges of fire request shots; holding fire yields a single shot.

Decomposition:
- faculty_fighter_pkg holds:
  - coord_t (logic [9:0]).
  - dir_e {DIR_RIGHT, DIR_LEFT}.
  - SCREEN_W=640, SCREEN_H=480.
  - proj_slot_t struct {active, x, y, dir}.
- Sub-module proj_slot: one slot's registers, move, bound check, hit check and pixel test. It is instantiated NUM_SLOTS times by a generate loop. The pool top keeps the synchroniser, edge detectors, cooldown counter, free-slot priority encoder and hit reduction.

Test Plan:
- Single shot to hit:
  - Setup: fire edge, dir=0, shooter (281,387), target (360,355,42,64).
  - Required: spawn at slot 0 with X=281 on the next tick. Hit on movement tick 20 (X=361). hit=1 for 1 Clk, hit_count=1, active_mask→0000.
- Cooldown drop: fire edges on ticks 0 and 5 with COOLDOWN_FRAMES=15. Required: only the first spawns and the second is dropped. A fire edge on tick 16 spawns in slot 1.
- Edge despawn:
  - Right: dir=0, spawn at X=630 → 634, then deactivates on the 2nd tick (638 > 635).
  - Left: dir=1, spawn at X=6 → deactivates on the 1st tick (2 < 4). No hit in either case.
- Pool full: COOLDOWN_FRAMES=0, 5 fire edges on consecutive ticks, target off-path. Required: slots 0–3 fill and the 5th shot is dropped. Once slot 0 despawns, the next shot takes slot 0, one tick later.
- Simultaneous hits: 2 slots enter the target on the same tick. Required: a single 1-Clk hit pulse, hit_count=2.
- Clears:
  - Reset asserted mid-flight: all outputs return to 0 asynchronously.
  - enable dropped: active_mask=0 on the next Clk.
  - Autofire (macro defined): fire held high for 40 ticks → spawns on ticks 0, 16, 32.
